// File: rtl/fifo_stream_reader_if.sv
// FIFO read port and valid/ready stream seen by the read-side adapter.
// master: the adapter; slave: the FIFO/consumer environment.
interface fifo_stream_reader_if #(
    parameter int BITS = 32
);
    logic            fifo_rd_en;
    logic [BITS-1:0] fifo_rd_data;
    logic            fifo_rd_empty;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic            flush;
    logic [31:0]     m_count;

    modport master (
        output fifo_rd_en, m_valid, m_data, m_count,
        input  fifo_rd_data, fifo_rd_empty, m_ready, flush
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_count,
        output fifo_rd_data, fifo_rd_empty, m_ready, flush
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-domain adapter: FIFO read port to valid/ready stream through a
// small prefetch buffer with credit-limited read issue and sync flush.
module fifo_stream_reader #(
    parameter int BITS  = 32,
    parameter int DEPTH = 2
) (
    input logic                  rd_clk,
    input logic                  rd_rst,
    fifo_stream_reader_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW:0]     occ_q, occ_d;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic            inflight_q;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [31:0]     cnt_q;
    logic            m_valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [LW-1:0]   level;

    assign m_valid = (occ_q != '0) && !bus.flush && (state_q != FLUSH);
    assign pop     = m_valid && bus.m_ready;
    // A word landing during a flush cycle is dropped, not buffered.
    assign push    = inflight_q && !bus.flush;

    // Buffered + in-flight words after this cycle's pop must leave room.
    assign level = LW'(occ_q) + LW'(inflight_q) - LW'(pop);
    assign issue = !rd_rst && !bus.fifo_rd_empty && !bus.flush
                   && (state_q != FLUSH) && (int'(level) < DEPTH);

    assign bus.fifo_rd_en = issue;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = mem_q[rptr_q];
    assign bus.m_count    = cnt_q;

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue) state_d = STREAM;
            end
            STREAM: begin
                if (occ_q == '0 && !inflight_q && bus.fifo_rd_empty)
                    state_d = IDLE;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = FLUSH;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= issue;
            if (bus.flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
            end
            if (pop) cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= bus.fifo_rd_data;
        end
    end

    // The credit limit makes a push into a full buffer impossible.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) assert (!(push && int'(occ_q) == DEPTH));
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and a
// scoreboard of expected stream words.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.BITS(32)) bus ();

    fifo_stream_reader #(
        .BITS (32),
        .DEPTH(2)
    ) dut (
        .rd_clk(clk),
        .rd_rst(rst),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] fifo_q [$];
    logic [31:0] exp_q  [$];
    int          rd_total = 0;
    int          dlv      = 0;
    int          bad_rd   = 0;
    int          cyc_n    = 0;
    logic [31:0] exp_cnt  = 0;
    logic        s_rd_en, s_valid, s_pop;
    logic [31:0] s_data, s_count;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 32'(i));
            exp_q.push_back(base + 32'(i));
        end
        bus.fifo_rd_empty = (fifo_q.size() == 0);
    endtask

    // One clock cycle: sample at negedge, check, then model the FIFO.
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        s_rd_en = bus.fifo_rd_en;
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_count = bus.m_count;
        s_pop   = s_valid && bus.m_ready;
        if (s_rd_en && bus.fifo_rd_empty) bad_rd++;
        if (hold_prev && !bus.flush) begin
            chk("hold_valid", 32'(s_valid), 1);
            chk("hold_data", s_data, hold_data);
        end
        hold_prev = s_valid && !bus.m_ready;
        hold_data = s_data;
        if (s_pop) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", s_data, e);
            end
            dlv++;
            exp_cnt = exp_cnt + 32'd1;
        end
        cyc_n++;
        @(posedge clk);
        #1;
        if (s_rd_en && fifo_q.size() != 0) begin
            bus.fifo_rd_data = fifo_q.pop_front();
            rd_total++;
        end
        bus.fifo_rd_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int target, input int budget);
        for (int i = 0; i < budget && dlv < target; i++) cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, first, last, vcnt, lost;
        logic [31:0] first_w;
        logic got;

        // Reset with a non-empty FIFO flag
        rst = 1'b1;
        bus.fifo_rd_empty = 1'b0;
        bus.fifo_rd_data = '0;
        bus.m_ready = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_count", bus.m_count, 0);
        chk("rst_data", bus.m_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.fifo_rd_empty = 1'b1;

        // Single word, latency 2
        bus.m_ready = 1'b1;
        load(1, 32'hA5A5_0001);
        cyc();
        chk("t2_rd_en_c0", 32'(s_rd_en), 1);
        chk("t2_valid_c0", 32'(s_valid), 0);
        cyc();
        chk("t2_valid_c1", 32'(s_valid), 0);
        cyc();
        chk("t2_valid_c2", 32'(s_valid), 1);
        chk("t2_data_c2", s_data, 32'hA5A5_0001);
        cyc();
        chk("t2_count", s_count, 1);
        chk("t2_valid_c3", 32'(s_valid), 0);
        chk("t2_idle", 32'(dut.state_q), 0);

        // Streaming 16 words back to back
        load(16, 32'd0);
        n = dlv + 16;
        first = -1;
        last = -1;
        vcnt = 0;
        for (int i = 0; i < 60 && dlv < n; i++) begin
            cyc();
            if (s_pop) begin
                if (first < 0) first = cyc_n;
                last = cyc_n;
                vcnt++;
            end
        end
        chk("t3_delivered", 32'(dlv), 32'(n));
        chk("t3_contig", 32'(last - first + 1), 16);
        chk("t3_pops", 32'(vcnt), 16);
        chk("t3_no_rd_empty", 32'(bad_rd), 0);

        // Backpressure
        bus.m_ready = 1'b0;
        load(8, 32'd0);
        n = dlv + 8;
        repeat (10) cyc();
        chk("t4_occ_full", 32'(dut.occ_q), 2);
        chk("t4_rd_en_low", 32'(s_rd_en), 0);
        chk("t4_valid", 32'(s_valid), 1);
        chk("t4_data0", s_data, 0);
        bus.m_ready = 1'b1;
        drain(n, 40);
        chk("t4_delivered", 32'(dlv), 32'(n));

        // Flush with a full buffer
        bus.m_ready = 1'b0;
        load(8, 32'd100);
        repeat (4) cyc();
        chk("t5_occ_full", 32'(dut.occ_q), 2);
        lost = rd_total - dlv;
        chk("t5_lost", 32'(lost), 2);
        repeat (lost) void'(exp_q.pop_front());
        n = dlv + 8 - lost;
        bus.flush = 1'b1;
        bus.m_ready = 1'b1;
        cyc();
        chk("t5_blk0_valid", 32'(s_valid), 0);
        chk("t5_blk0_rd_en", 32'(s_rd_en), 0);
        bus.flush = 1'b0;
        cyc();
        chk("t5_blk1_valid", 32'(s_valid), 0);
        chk("t5_blk1_rd_en", 32'(s_rd_en), 0);
        got = 1'b0;
        first_w = '0;
        for (int i = 0; i < 40 && dlv < n; i++) begin
            cyc();
            if (s_pop && !got) begin
                first_w = s_data;
                got = 1'b1;
            end
        end
        chk("t5_first_word", first_w, 32'd102);
        chk("t5_delivered", 32'(dlv), 32'(n));
        cyc();
        chk("t5_count", s_count, exp_cnt);

        // Counter wrap
        bus.m_ready = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        load(3, 32'h600);
        bus.m_ready = 1'b1;
        n = dlv + 3;
        drain(n, 20);
        cyc();
        chk("t6_count_wrap", s_count, 1);
        chk("t6_count_model", s_count, exp_cnt);

        // Pointer wrap under random backpressure
        load(40, 32'h7000);
        n = dlv + 40;
        for (int i = 0; i < 100; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        bus.m_ready = 1'b1;
        drain(n, 120);
        chk("t6_delivered", 32'(dlv), 32'(n));
        chk("t6_sb_empty", 32'(exp_q.size()), 0);
        cyc();
        chk("t6_valid_end", 32'(s_valid), 0);
        chk("t6_count_end", s_count, exp_cnt);
        chk("t6_no_rd_empty", 32'(bad_rd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
